// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback always wins, long-unit results
// are bypassed or buffered in a small FIFO, with starvation stall and pending-rd check.
module rf_wb_arbiter #(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipe_we,
    input  logic [4:0]  pipe_rd,
    input  logic [31:0] pipe_val,
    input  logic        lu_valid,
    output logic        lu_ready,
    input  logic [4:0]  lu_rd,
    input  logic [31:0] lu_val,
    output logic        rf_we,
    output logic [4:0]  rf_rd,
    output logic [31:0] rf_wdata,
    output logic        stall_req,
    input  logic [4:0]  chk_rd,
    output logic        chk_busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [7:0]    SMAX     = 8'(STARVE_MAX);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    starve_q, starve_d;
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [4:0]    rd_mem_q  [DEPTH];
    logic [31:0]   val_mem_q [DEPTH];

    logic fifo_empty, pipe_slot, lu_push, bypass, pop, push, fifo_hit;

    assign fifo_empty = (count_q == '0);
    assign pipe_slot  = pipe_we && (pipe_rd != 5'd0);
    assign lu_ready   = !rst && (count_q != FULL_CNT);
    assign lu_push    = lu_valid && lu_ready;
    assign bypass     = !pipe_slot && fifo_empty && lu_push;
    assign pop        = !pipe_slot && !fifo_empty;
    assign push       = lu_push && (lu_rd != 5'd0) && !bypass;
    assign stall_req  = !rst && (starve_q == SMAX);

    always_comb begin
        rf_we    = 1'b0;
        rf_rd    = 5'd0;
        rf_wdata = 32'd0;
        if (!rst) begin
            if (pipe_slot) begin
                rf_we    = 1'b1;
                rf_rd    = pipe_rd;
                rf_wdata = pipe_val;
            end else if (!fifo_empty) begin
                rf_we    = 1'b1;
                rf_rd    = rd_mem_q[rd_ptr_q];
                rf_wdata = val_mem_q[rd_ptr_q];
            end else if (bypass && lu_rd != 5'd0) begin
                rf_we    = 1'b1;
                rf_rd    = lu_rd;
                rf_wdata = lu_val;
            end
        end
    end

    // An entry popped this cycle still reads busy: its write is only now landing.
    always_comb begin
        fifo_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && rd_mem_q[i] == chk_rd) fifo_hit = 1'b1;
        end
        chk_busy = !rst && (chk_rd != 5'd0) &&
                   (fifo_hit || (push && lu_rd == chk_rd));
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        valid_d  = valid_q;
        count_d  = count_q + CW'(push) - CW'(pop);
        starve_d = starve_q;
        if (pop) begin
            rd_ptr_d          = rd_ptr_q + AW'(1);
            valid_d[rd_ptr_q] = 1'b0;
        end
        if (push) begin
            wr_ptr_d          = wr_ptr_q + AW'(1);
            valid_d[wr_ptr_q] = 1'b1;
        end
        if (fifo_empty || pop)    starve_d = 8'd0;
        else if (starve_q != SMAX) starve_d = starve_q + 8'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            starve_q <= '0;
            valid_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            starve_q <= starve_d;
            valid_q  <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            rd_mem_q[wr_ptr_q]  <= lu_rd;
            val_mem_q[wr_ptr_q] <= lu_val;
        end
    end
endmodule
